// File: rtl/mul_result_queue_if.sv
// -----------------------------------------------------------------------------
// mul_result_queue_if
//   Register-file writeback channel carrying one multiplier result per
//   valid/ready handshake.
//
//   wb_valid_o  head entry valid               (queue -> writeback port)
//   wb_ready_i  writeback port accepts head    (writeback port -> queue)
//   wb_rd_o     head entry destination tag     (queue -> writeback port)
//   wb_data_o   head entry result data         (queue -> writeback port)
//
//   master: the result queue. slave: the register-file writeback port.
// -----------------------------------------------------------------------------
interface mul_result_queue_if #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 64
);
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [TAG_W-1:0]  wb_rd_o;
    logic [DATA_W-1:0] wb_data_o;

    modport master (
        output wb_valid_o,
        output wb_rd_o,
        output wb_data_o,
        input  wb_ready_i
    );

    modport slave (
        input  wb_valid_o,
        input  wb_rd_o,
        input  wb_data_o,
        output wb_ready_i
    );
endinterface

// File: rtl/mul_result_queue.sv
// -----------------------------------------------------------------------------
// mul_result_queue
//   Writeback-side companion to the scalar multiplier. A tracker FSM runs in
//   lock-step with the multiplier (IDLE -> MULT -> DONE) so it knows the one
//   cycle in which mul_result_i is valid. That result is pushed, with the
//   destination tag captured at request time, into a small FIFO whose head is
//   offered to the register-file writeback port with valid/ready.
//
// Ports
//   clk_i          clock, all state on rising edge
//   rstn_i         asynchronous active-low reset
//   kill_i         aborts the in-flight multiply (never touches queued entries)
//   mul_request_i  request also seen by the multiplier
//   rd_tag_i       destination tag, sampled with an accepted request
//   mul_result_i   multiplier result, meaningful only in the DONE cycle
//   wb             writeback channel (master side)
//   full_o         issue must hold off mul_request_i while high
//   count_o        number of occupied FIFO entries
// -----------------------------------------------------------------------------
module mul_result_queue #(
    parameter int DEPTH  = 2,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 64
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     kill_i,
    input  logic                     mul_request_i,
    input  logic [TAG_W-1:0]         rd_tag_i,
    input  logic [DATA_W-1:0]        mul_result_i,
    mul_result_queue_if.master       wb,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_MULT = 2'd1,
        T_DONE = 2'd2
    } track_e;

    track_e             state_q, state_d;
    logic               accept;
    logic               push;
    logic               pop;
    logic               inflight;
    logic [TAG_W-1:0]   tag_q;

    logic [TAG_W-1:0]   mem_tag  [DEPTH];
    logic [DATA_W-1:0]  mem_data [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W:0]     occupancy;

    // ------------------------------------------------------------------
    // Tracker FSM
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        push    = 1'b0;
        case (state_q)
            T_IDLE: begin
                // A request while full is illegal; it is dropped, not queued.
                if (mul_request_i && !kill_i && !full_o) begin
                    state_d = T_MULT;
                    accept  = 1'b1;
                end
            end
            T_MULT: begin
                state_d = kill_i ? T_IDLE : T_DONE;
            end
            T_DONE: begin
                state_d = T_IDLE;
                push    = !kill_i;
            end
            default: begin
                state_d = T_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of block order.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= T_IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= rd_tag_i;
            end
        end
    end

    assign inflight = (state_q != T_IDLE);

    // Reserve a slot for the in-flight op as soon as it is accepted, so the
    // DONE-cycle push can never find the FIFO full. Built from registered
    // state only; a slot freed by a pop this cycle shows up next cycle.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
    assign full_o    = (occupancy >= (CNT_W+1)'(DEPTH));

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    assign pop = wb.wb_valid_o && wb.wb_ready_i;

    // NOTE: the storage array is reset here because the head outputs are read
    // straight from it and must be zero out of reset; this is affordable only
    // because the queue is a handful of entries deep.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_tag[i]  <= '0;
                mem_data[i] <= '0;
            end
        end else if (push) begin
            mem_tag[wr_ptr_q]  <= tag_q;
            mem_data[wr_ptr_q] <= mul_result_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Head is a mux from the array: it only moves on a pop, so it is stable
    // while the writeback port stalls. When empty it shows stale/reset data.
    assign wb.wb_valid_o = (count_q != '0);
    assign wb.wb_rd_o    = mem_tag[rd_ptr_q];
    assign wb.wb_data_o  = mem_data[rd_ptr_q];
    assign count_o       = count_q;

endmodule

// File: tb/tb_mul_result_queue.sv
// -----------------------------------------------------------------------------
// tb_mul_result_queue
//   Self-checking bench for mul_result_queue (DEPTH=2, TAG_W=5, DATA_W=64).
//   The bench plays the multiplier: it drives mul_result_i only in the DONE
//   cycle. Expected writeback entries go into a scoreboard queue when a
//   request is driven and are compared whenever the writeback port pops.
// -----------------------------------------------------------------------------
module tb_mul_result_queue;

    localparam int DEPTH  = 2;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 64;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    // kill_stage: 0 none, 1 kill in MULT cycle, 2 kill in DONE cycle
    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        int                kill_stage;
        bit                hold_req;
        bit                exp_push;
    } vec_t;

    logic                 clk_i = 1'b0;
    logic                 rstn_i;
    logic                 kill_i;
    logic                 mul_request_i;
    logic [TAG_W-1:0]     rd_tag_i;
    logic [DATA_W-1:0]    mul_result_i;
    logic                 full_o;
    logic [$clog2(DEPTH):0] count_o;

    mul_result_queue_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) wb_if ();

    mul_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .kill_i        (kill_i),
        .mul_request_i (mul_request_i),
        .rd_tag_i      (rd_tag_i),
        .mul_result_i  (mul_result_i),
        .wb            (wb_if.master),
        .full_o        (full_o),
        .count_o       (count_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Writeback consumer: every accepted head entry must match the oldest
    // outstanding expectation.
    always @(negedge clk_i) begin
        if (rstn_i && wb_if.wb_valid_o && wb_if.wb_ready_i) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pop_tag", 64'(wb_if.wb_rd_o), 64'(e.tag));
                check("pop_data", wb_if.wb_data_o, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One multiplier op starting in the current cycle (T). Returns 1 ns after
    // the edge that ends T+2 (or T+1 when killed in MULT), tracker back idle.
    task automatic run_op(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data,
                          input int kill_stage, input bit hold_req, input bit exp_push);
        mul_request_i = 1'b1;
        rd_tag_i      = tag;
        if (exp_push) sb.push_back('{tag: tag, data: data});
        tick();                                    // now T+1, MULT
        if (hold_req) rd_tag_i = ~tag;             // ignored outside IDLE
        else          mul_request_i = 1'b0;
        if (kill_stage == 1) begin
            kill_i = 1'b1;
            tick();
            kill_i        = 1'b0;
            mul_request_i = 1'b0;
            return;
        end
        tick();                                    // now T+2, DONE
        mul_result_i = data;
        if (kill_stage == 2) kill_i = 1'b1;
        tick();                                    // now T+3
        mul_result_i  = '0;
        kill_i        = 1'b0;
        mul_request_i = 1'b0;
    endtask

    initial begin
        rstn_i            = 1'b0;
        kill_i            = 1'b0;
        mul_request_i     = 1'b0;
        rd_tag_i          = '0;
        mul_result_i      = '0;
        wb_if.wb_ready_i  = 1'b0;

        vecs[0] = '{tag: 5'd7,  data: 64'hDEAD_BEEF_0000_0001, kill_stage: 0, hold_req: 1'b0, exp_push: 1'b1};
        vecs[1] = '{tag: 5'd3,  data: 64'h3333,                kill_stage: 1, hold_req: 1'b0, exp_push: 1'b0};
        vecs[2] = '{tag: 5'd8,  data: 64'h8888,                kill_stage: 2, hold_req: 1'b0, exp_push: 1'b0};
        vecs[3] = '{tag: 5'd9,  data: 64'h0,                   kill_stage: 0, hold_req: 1'b0, exp_push: 1'b1};
        vecs[4] = '{tag: 5'd31, data: 64'hFFFF_FFFF_FFFF_FFFF, kill_stage: 0, hold_req: 1'b1, exp_push: 1'b1};
        vecs[5] = '{tag: 5'd0,  data: 64'h1,                   kill_stage: 0, hold_req: 1'b0, exp_push: 1'b1};

        // Reset values
        #12;
        check("rst_valid", 64'(wb_if.wb_valid_o), 64'd0);
        check("rst_rd",    64'(wb_if.wb_rd_o),    64'd0);
        check("rst_data",  wb_if.wb_data_o,       64'd0);
        check("rst_full",  64'(full_o),           64'd0);
        check("rst_count", 64'(count_o),          64'd0);
        tick();
        rstn_i = 1'b1;
        tick();

        // Latency: request tag 5 at T, result at T+2, visible at T+3 only
        wb_if.wb_ready_i = 1'b1;
        mul_request_i    = 1'b1;
        rd_tag_i         = 5'd5;
        sb.push_back('{tag: 5'd5, data: 64'h1234});
        tick();
        mul_request_i = 1'b0;
        check("lat_t1_valid", 64'(wb_if.wb_valid_o), 64'd0);
        tick();
        mul_result_i = 64'h1234;
        check("lat_t2_valid", 64'(wb_if.wb_valid_o), 64'd0);
        tick();
        mul_result_i = '0;
        check("lat_t3_valid", 64'(wb_if.wb_valid_o), 64'd1);
        check("lat_t3_rd",    64'(wb_if.wb_rd_o),    64'd5);
        check("lat_t3_data",  wb_if.wb_data_o,       64'h1234);
        tick();
        check("lat_t4_valid", 64'(wb_if.wb_valid_o), 64'd0);

        // Table: kills, zero data, request held through the op, back-to-back
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].tag, vecs[i].data, vecs[i].kill_stage, vecs[i].hold_req, vecs[i].exp_push);
            check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].exp_push));
            check($sformatf("vec%0d_full", i),  64'(full_o),  64'd0);
        end
        tick();
        check("table_drain_count", 64'(count_o), 64'd0);

        // Backpressure: two results queue up, third request while full is dropped
        wb_if.wb_ready_i = 1'b0;
        run_op(5'd1, 64'hA, 0, 1'b0, 1'b1);
        run_op(5'd2, 64'hB, 0, 1'b0, 1'b1);
        check("bp_count", 64'(count_o), 64'd2);
        check("bp_full",  64'(full_o),  64'd1);
        mul_request_i = 1'b1;
        rd_tag_i      = 5'd7;
        tick();
        mul_request_i = 1'b0;
        tick();
        tick();
        check("bp_ign_count", 64'(count_o),          64'd2);
        check("bp_ign_full",  64'(full_o),           64'd1);
        check("bp_hold_rd",   64'(wb_if.wb_rd_o),    64'd1);
        check("bp_hold_data", wb_if.wb_data_o,       64'hA);
        wb_if.wb_ready_i = 1'b1;
        tick();
        tick();
        tick();
        check("bp_drain_count", 64'(count_o), 64'd0);
        check("bp_drain_full",  64'(full_o),  64'd0);

        // Simultaneous push and pop while full_o is high
        wb_if.wb_ready_i = 1'b0;
        run_op(5'd9, 64'h99, 0, 1'b0, 1'b1);
        mul_request_i = 1'b1;
        rd_tag_i      = 5'd10;
        sb.push_back('{tag: 5'd10, data: 64'h10});
        tick();                                    // MULT
        mul_request_i = 1'b0;
        check("pp_full_mult", 64'(full_o), 64'd1);
        tick();                                    // DONE
        mul_result_i     = 64'h10;
        wb_if.wb_ready_i = 1'b1;
        tick();
        mul_result_i = '0;
        check("pp_count", 64'(count_o),       64'd1);
        check("pp_rd",    64'(wb_if.wb_rd_o), 64'd10);
        check("pp_data",  wb_if.wb_data_o,    64'h10);
        tick();
        check("pp_drain_count", 64'(count_o), 64'd0);

        // Reset in the middle of an op with one entry queued
        wb_if.wb_ready_i = 1'b0;
        run_op(5'd4, 64'h44, 0, 1'b0, 1'b1);
        mul_request_i = 1'b1;
        rd_tag_i      = 5'd11;
        tick();                                    // MULT
        mul_request_i = 1'b0;
        rstn_i        = 1'b0;
        #1;
        sb.delete();
        check("mrst_valid", 64'(wb_if.wb_valid_o), 64'd0);
        check("mrst_rd",    64'(wb_if.wb_rd_o),    64'd0);
        check("mrst_data",  wb_if.wb_data_o,       64'd0);
        check("mrst_full",  64'(full_o),           64'd0);
        check("mrst_count", 64'(count_o),          64'd0);
        tick();
        rstn_i = 1'b1;
        tick();
        wb_if.wb_ready_i = 1'b1;
        run_op(5'd12, 64'h5A5, 0, 1'b0, 1'b1);
        check("post_rst_rd",   64'(wb_if.wb_rd_o), 64'd12);
        check("post_rst_data", wb_if.wb_data_o,    64'h5A5);
        tick();
        tick();
        check("end_count", 64'(count_o),   64'd0);
        check("end_sb",    64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
